uart_pkt_rx: RTL and testbench

Framing stage directly downstream of the UART receiver. Consumes its byte stream (dout, dout_valid, par_err) and parses frames of the form SOF, LEN, LEN payload bytes, CHK. Buffers the payload internally and releases it on a valid/ready byte stream only after the checksum verifies. Reports each good frame and each error with a one-cycle status pulse.

---
 rtl/uart_pkt_rx.sv | 152 +++++++++++++++
 tb/tb_uart_pkt_rx.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_rx.sv
// Frame parser behind the UART receiver: SOF, LEN, LEN payload bytes, CHK.
// Payload is held in a local buffer and released on valid/ready only once the checksum matches.
module uart_pkt_rx #(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_par_err,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_ok,
  output logic       err,
  output logic [2:0] err_code
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] E_PAR = 3'd1;
  localparam logic [2:0] E_LEN = 3'd2;
  localparam logic [2:0] E_CHK = 3'd3;
  localparam logic [2:0] E_TMO = 3'd4;
  localparam logic [2:0] E_OVR = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_SEND} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [MAX_LEN];
  logic [7:0]    len, sum;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic          err_nx, ok_nx;
  logic [2:0]    code_nx;
  logic          frame_open, tmo_hit, wr_last, rd_last, len_bad, xfer;

  assign frame_open = state inside {S_LEN, S_DATA, S_CHK};
  // A byte arriving on the terminal cycle keeps the frame alive.
  assign tmo_hit    = frame_open && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign wr_last    = 8'(wr_ptr) == (len - 8'd1);
  assign rd_last    = 8'(rd_ptr) == (len - 8'd1);
  assign len_bad    = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));

  assign pkt_valid  = state == S_SEND;
  assign pkt_last   = pkt_valid && rd_last;
  assign pkt_data   = pkt_valid ? mem[rd_ptr] : 8'd0;
  assign xfer       = pkt_valid && pkt_ready;

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    code_nx  = 3'd0;
    ok_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && !rx_par_err && rx_data == SOF) state_nx = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_par_err) begin
            err_nx = 1'b1; code_nx = E_PAR; state_nx = S_IDLE;
          end else if (len_bad) begin
            err_nx = 1'b1; code_nx = E_LEN; state_nx = S_IDLE;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (rx_par_err) begin
            err_nx = 1'b1; code_nx = E_PAR; state_nx = S_IDLE;
          end else if (wr_last) begin
            state_nx = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_par_err) begin
            err_nx = 1'b1; code_nx = E_PAR; state_nx = S_IDLE;
          end else if (rx_data != sum) begin
            err_nx = 1'b1; code_nx = E_CHK; state_nx = S_IDLE;
          end else begin
            ok_nx = 1'b1; state_nx = S_SEND;
          end
        end
      end
      S_SEND: begin
        // Bytes arriving while draining are dropped, never parsed.
        if (rx_valid) begin
          err_nx = 1'b1; code_nx = E_OVR;
        end
        if (xfer && rd_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (tmo_hit) begin
      err_nx = 1'b1; code_nx = E_TMO; state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= 8'd0;
      sum      <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
      err_code <= 3'd0;
      frame_ok <= 1'b0;
    end else begin
      state    <= state_nx;
      err      <= err_nx;
      err_code <= code_nx;
      frame_ok <= ok_nx;
      tmo_cnt  <= (frame_open && !rx_valid && !tmo_hit) ? tmo_cnt + TW'(1) : '0;
      if (rx_valid && !rx_par_err) begin
        case (state)
          S_LEN: begin
            if (!len_bad) begin
              len    <= rx_data;
              sum    <= rx_data;
              wr_ptr <= '0;
            end
          end
          S_DATA: begin
            sum    <= sum + rx_data;
            wr_ptr <= wr_ptr + PW'(1);
          end
          S_CHK: begin
            if (rx_data == sum) rd_ptr <= '0;
          end
          default: ;
        endcase
      end
      if (xfer) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && rx_valid && !rx_par_err) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: directed frame scenarios plus randomized frames
// checked against a rule-based frame model.
module tb_uart_pkt_rx;

  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_par_err = 1'b0;
  logic       pkt_ready = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid, pkt_last, frame_ok, err;
  logic [2:0] err_code;

  int n_cmp = 0;
  int n_fail = 0;
  bit rdy_rand = 1'b0;

  logic [7:0] q_data[$];
  bit         q_last[$];
  logic [2:0] q_err[$];
  int         ok_cnt = 0;

  logic [7:0] tx_q[$];
  bit         tx_par[$];
  logic [7:0] exp_q[$];
  int         exp_err;

  uart_pkt_rx #(.SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last),
    .frame_ok(frame_ok), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_valid && pkt_ready) begin
      q_data.push_back(pkt_data);
      q_last.push_back(pkt_last);
    end
    if (err) q_err.push_back(err_code);
    if (frame_ok) ok_cnt++;
    n_cmp++;
    if ((err && frame_ok) || (!err && err_code != 3'd0) || (!pkt_valid && (pkt_last || pkt_data != 8'd0))) begin
      n_fail++;
      $display("FAIL invariant: err=%0b frame_ok=%0b err_code=%0d pkt_valid=%0b pkt_last=%0b pkt_data=%h; required no err+frame_ok, err_code 0 without err, idle outputs 0",
               err, frame_ok, err_code, pkt_valid, pkt_last, pkt_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) pkt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] d, input bit p);
    rx_data = d; rx_valid = 1'b1; rx_par_err = p;
    step();
    rx_data = 8'd0; rx_valid = 1'b0; rx_par_err = 1'b0;
  endtask

  task automatic tx_clear();
    tx_q.delete(); tx_par.delete();
  endtask

  task automatic tx_add(input logic [7:0] d, input bit p);
    tx_q.push_back(d); tx_par.push_back(p);
  endtask

  task automatic load_std(input logic [7:0] chk);
    tx_clear();
    tx_add(SOF, 0); tx_add(8'h03, 0); tx_add(8'h11, 0); tx_add(8'h22, 0); tx_add(8'h33, 0); tx_add(chk, 0);
  endtask

  task automatic send_tx(input int max_gap);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) step();
      send_byte(tx_q[i], tx_par[i]);
    end
  endtask

  task automatic mon_clear();
    q_data.delete(); q_last.delete(); q_err.delete();
  endtask

  task automatic drain(input int n, output bit timed_out);
    int cyc = 0;
    while (q_data.size() < n && cyc < 400) begin
      step();
      cyc++;
    end
    timed_out = (q_data.size() < n);
  endtask

  // Expected outcome of tx_q from the framing rules: -1 ignored, 0 good (exp_q = payload), else err code.
  function automatic void run_model();
    int len, s;
    exp_q.delete();
    exp_err = 0;
    if (tx_q.size() < 2 || tx_q[0] != SOF || tx_par[0]) begin exp_err = -1; return; end
    if (tx_par[1]) begin exp_err = 1; return; end
    len = int'(tx_q[1]);
    if (len < 1 || len > MAX_LEN) begin exp_err = 2; return; end
    for (int i = 2; i <= len + 2; i++) if (tx_par[i]) begin exp_err = 1; return; end
    s = len;
    for (int i = 0; i < len; i++) s += int'(tx_q[2 + i]);
    if ((s % 256) != int'(tx_q[len + 2])) begin exp_err = 3; return; end
    for (int i = 0; i < len; i++) exp_q.push_back(tx_q[2 + i]);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    n_cmp++;
    if ({pkt_valid, pkt_last, frame_ok, err} !== 4'b0 || err_code !== 3'd0 || pkt_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%0b last=%0b ok=%0b err=%0b code=%0d data=%h, required all 0",
               pkt_valid, pkt_last, frame_ok, err, err_code, pkt_data);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp [3];
    int okc;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    mon_clear(); pkt_ready = 1'b1; okc = ok_cnt;
    load_std(8'h69); send_tx(0);
    n_cmp++;
    if (frame_ok !== 1'b1 || pkt_valid !== 1'b1 || pkt_data !== 8'h11 || pkt_last !== 1'b0) begin
      n_fail++;
      $display("FAIL good_first: ok=%0b valid=%0b data=%h last=%0b, required 1 1 11 0", frame_ok, pkt_valid, pkt_data, pkt_last);
    end
    step();
    n_cmp++;
    if (frame_ok !== 1'b0 || pkt_valid !== 1'b1 || pkt_data !== 8'h22 || pkt_last !== 1'b0) begin
      n_fail++;
      $display("FAIL good_second: ok=%0b valid=%0b data=%h last=%0b, required 0 1 22 0", frame_ok, pkt_valid, pkt_data, pkt_last);
    end
    step();
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_data !== 8'h33 || pkt_last !== 1'b1) begin
      n_fail++;
      $display("FAIL good_third: valid=%0b data=%h last=%0b, required 1 33 1", pkt_valid, pkt_data, pkt_last);
    end
    step();
    n_cmp++;
    if (pkt_valid !== 1'b0) begin
      n_fail++; $display("FAIL good_end: valid=%0b, required 0", pkt_valid);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= q_data.size() || q_data[i] !== exp[i] || q_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL good_xfer[%0d]: got %0d transfers, data=%h last=%0b, required %h last=%0b",
                 i, q_data.size(), (i < q_data.size()) ? q_data[i] : 8'hxx, (i < q_last.size()) ? q_last[i] : 1'b0, exp[i], (i == 2));
      end
    end
    n_cmp++;
    if (ok_cnt - okc != 1 || q_err.size() != 0 || q_data.size() != 3) begin
      n_fail++;
      $display("FAIL good_counts: frame_ok=%0d err=%0d xfers=%0d, required 1 0 3", ok_cnt - okc, q_err.size(), q_data.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3];
    logic [7:0] d0;
    bit v0, r0, l0;
    int cyc;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    mon_clear(); pkt_ready = 1'b0;
    load_std(8'h69); send_tx(0);
    cyc = 0;
    while (q_data.size() < 3 && cyc < 20) begin
      v0 = pkt_valid; r0 = pkt_ready; d0 = pkt_data; l0 = pkt_last;
      step();
      cyc++;
      if (v0 && !r0) begin
        n_cmp++;
        if (pkt_valid !== 1'b1 || pkt_data !== d0 || pkt_last !== l0) begin
          n_fail++;
          $display("FAIL bp_stable: valid=%0b data=%h last=%0b, required 1 %h %0b", pkt_valid, pkt_data, pkt_last, d0, l0);
        end
      end
      pkt_ready = ~pkt_ready;
    end
    n_cmp++;
    if (q_data.size() != 3 || pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: xfers=%0d valid=%0b, required 3 0", q_data.size(), pkt_valid);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= q_data.size() || q_data[i] !== exp[i] || q_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL bp_xfer[%0d]: data=%h, required %h", i, (i < q_data.size()) ? q_data[i] : 8'hxx, exp[i]);
      end
    end
    n_cmp++;
    if (q_err.size() != 0) begin
      n_fail++; $display("FAIL bp_err: errors=%0d, required 0", q_err.size());
    end
  endtask

  task automatic test_bad_checksum();
    int okc;
    bit to;
    mon_clear(); pkt_ready = 1'b1; okc = ok_cnt;
    load_std(8'h68); send_tx(0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd3 || pkt_valid !== 1'b0 || frame_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_err: err=%0b code=%0d valid=%0b ok=%0b, required 1 3 0 0", err, err_code, pkt_valid, frame_ok);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || err_code !== 3'd0 || pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_pulse: err=%0b code=%0d valid=%0b, required 0 0 0", err, err_code, pkt_valid);
    end
    load_std(8'h69); send_tx(0);
    drain(3, to);
    n_cmp++;
    if (to || q_data.size() != 3 || q_data[0] !== 8'h11 || q_data[1] !== 8'h22 || q_data[2] !== 8'h33
        || ok_cnt - okc != 1 || q_err.size() != 1) begin
      n_fail++;
      $display("FAIL chk_recover: timeout=%0b xfers=%0d ok=%0d errs=%0d, required 0 3 1 1", to, q_data.size(), ok_cnt - okc, q_err.size());
    end
  endtask

  task automatic test_len_noise();
    bit to;
    logic [7:0] b;
    int s;
    mon_clear(); pkt_ready = 1'b1;
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(SOF, 1); send_byte(8'h03, 0);
    step();
    n_cmp++;
    if (q_err.size() != 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL noise: errors=%0d err=%0b, required 0 0", q_err.size(), err);
    end
    send_byte(SOF, 0); send_byte(8'h00, 0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd2) begin
      n_fail++; $display("FAIL len_zero: err=%0b code=%0d, required 1 2", err, err_code);
    end
    step();
    send_byte(SOF, 0); send_byte(8'h11, 0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd2) begin
      n_fail++; $display("FAIL len_big: err=%0b code=%0d, required 1 2", err, err_code);
    end
    step();
    tx_clear(); tx_add(SOF, 0); tx_add(8'(MAX_LEN), 0); s = MAX_LEN;
    for (int i = 0; i < MAX_LEN; i++) begin
      b = 8'($urandom_range(0, 255)); s += int'(b); tx_add(b, 0);
    end
    tx_add(8'(s), 0);
    run_model(); send_tx(0);
    drain(MAX_LEN, to);
    n_cmp++;
    if (to || q_data.size() != exp_q.size() || q_data != exp_q || q_last[MAX_LEN-1] !== 1'b1 || q_err.size() != 2) begin
      n_fail++;
      $display("FAIL len_max: timeout=%0b xfers=%0d errs=%0d, required 0 %0d 2", to, q_data.size(), q_err.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout_parity();
    bit early, to;
    int okc;
    mon_clear(); pkt_ready = 1'b1;
    send_byte(SOF, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    early = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      if (err) early = 1'b1;
    end
    n_cmp++;
    if (early) begin
      n_fail++; $display("FAIL tmo_early: err seen before %0d cycles, required none", TIMEOUT);
    end
    step();
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd4) begin
      n_fail++; $display("FAIL tmo_fire: err=%0b code=%0d, required 1 4", err, err_code);
    end
    step();
    okc = ok_cnt;
    send_byte(SOF, 0); send_byte(8'h02, 0);
    repeat (TIMEOUT - 1) step();
    send_byte(8'h11, 0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_byte_wins: err=%0b code=%0d, required 0", err, err_code);
    end
    send_byte(8'h22, 0); send_byte(8'h35, 0);
    drain(2, to);
    n_cmp++;
    if (to || ok_cnt - okc != 1 || q_data.size() != 2 || q_data[0] !== 8'h11 || q_data[1] !== 8'h22) begin
      n_fail++;
      $display("FAIL tmo_late_frame: timeout=%0b ok=%0d xfers=%0d, required 0 1 2", to, ok_cnt - okc, q_data.size());
    end
    mon_clear(); okc = ok_cnt;
    send_byte(SOF, 0); send_byte(8'h02, 0); send_byte(8'h11, 1);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd1) begin
      n_fail++; $display("FAIL par_data: err=%0b code=%0d, required 1 1", err, err_code);
    end
    step();
    send_byte(SOF, 0); send_byte(8'h03, 1);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd1) begin
      n_fail++; $display("FAIL par_len: err=%0b code=%0d, required 1 1", err, err_code);
    end
    step();
    load_std(8'h69); tx_par[5] = 1'b1; send_tx(0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd1 || frame_ok !== 1'b0) begin
      n_fail++; $display("FAIL par_chk: err=%0b code=%0d ok=%0b, required 1 1 0", err, err_code, frame_ok);
    end
    step(); step();
    n_cmp++;
    if (q_data.size() != 0 || ok_cnt != okc || pkt_valid !== 1'b0) begin
      n_fail++; $display("FAIL par_no_out: xfers=%0d ok=%0d valid=%0b, required 0 0 0", q_data.size(), ok_cnt - okc, pkt_valid);
    end
  endtask

  task automatic test_overrun_reset();
    int okc;
    bit to;
    mon_clear(); pkt_ready = 1'b0; okc = ok_cnt;
    load_std(8'h69); send_tx(0);
    step(); step();
    send_byte(8'h44, 0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd5 || pkt_valid !== 1'b1 || pkt_data !== 8'h11 || pkt_last !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr: err=%0b code=%0d valid=%0b data=%h last=%0b, required 1 5 1 11 0", err, err_code, pkt_valid, pkt_data, pkt_last);
    end
    pkt_ready = 1'b1;
    drain(3, to);
    n_cmp++;
    if (to || q_data.size() != 3 || q_data[0] !== 8'h11 || q_data[1] !== 8'h22 || q_data[2] !== 8'h33 || ok_cnt - okc != 1) begin
      n_fail++; $display("FAIL ovr_data: timeout=%0b xfers=%0d ok=%0d, required 0 3 1", to, q_data.size(), ok_cnt - okc);
    end
    mon_clear();
    load_std(8'h69); send_tx(0);
    step(); step();
    send_byte(SOF, 0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 3'd5 || pkt_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_exit: err=%0b code=%0d valid=%0b, required 1 5 0", err, err_code, pkt_valid);
    end
    okc = ok_cnt;
    tx_clear(); tx_add(8'h03, 0); tx_add(8'h11, 0); tx_add(8'h22, 0); tx_add(8'h33, 0); tx_add(8'h69, 0);
    send_tx(0); step(); step();
    n_cmp++;
    if (ok_cnt != okc || q_err.size() != 1 || q_data.size() != 3) begin
      n_fail++; $display("FAIL ovr_not_parsed: ok=%0d errs=%0d xfers=%0d, required 0 1 3", ok_cnt - okc, q_err.size(), q_data.size());
    end
    pkt_ready = 1'b0;
    load_std(8'h69); send_tx(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (pkt_valid !== 1'b0 || pkt_data !== 8'd0) begin
      n_fail++; $display("FAIL rst_send: valid=%0b data=%h, required 0 00", pkt_valid, pkt_data);
    end
    mon_clear(); pkt_ready = 1'b1; okc = ok_cnt;
    load_std(8'h69); send_tx(0);
    drain(3, to);
    n_cmp++;
    if (to || q_data.size() != 3 || q_data[0] !== 8'h11 || q_data[1] !== 8'h22 || q_data[2] !== 8'h33 || ok_cnt - okc != 1) begin
      n_fail++; $display("FAIL rst_recover: timeout=%0b xfers=%0d ok=%0d, required 0 3 1", to, q_data.size(), ok_cnt - okc);
    end
  endtask

  task automatic test_random();
    int cat, len, s, okc, p;
    logic [7:0] b;
    bit to;
    rdy_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      cat = $urandom_range(0, 4);
      tx_clear();
      if (cat == 4) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom_range(0, 255));
          if (b == SOF) tx_add(b, 1);
          else tx_add(b, 1'($urandom_range(0, 1)));
        end
      end else begin
        if (cat == 2) len = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        else len = $urandom_range(1, MAX_LEN);
        tx_add(SOF, 0); tx_add(8'(len), 0); s = len;
        if (cat != 2) begin
          for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255)); s += int'(b); tx_add(b, 0);
          end
          if (cat == 1) tx_add(8'(s + $urandom_range(1, 255)), 0);
          else tx_add(8'(s), 0);
          if (cat == 3) begin
            p = $urandom_range(1, len + 2);
            tx_par[p] = 1'b1;
            while (tx_q.size() > p + 1) begin
              void'(tx_q.pop_back()); void'(tx_par.pop_back());
            end
          end
        end
      end
      run_model();
      mon_clear(); okc = ok_cnt;
      send_tx(3);
      if (exp_err == 0) begin
        drain(exp_q.size(), to);
        n_cmp++;
        if (to || q_data != exp_q || q_last.size() != exp_q.size() || q_last[exp_q.size()-1] !== 1'b1
            || ok_cnt - okc != 1 || q_err.size() != 0) begin
          n_fail++;
          $display("FAIL rand_good[%0d]: timeout=%0b xfers=%0d ok=%0d errs=%0d, required 0 %0d 1 0",
                   f, to, q_data.size(), ok_cnt - okc, q_err.size(), exp_q.size());
        end
      end else begin
        step(); step();
        n_cmp++;
        if ((exp_err < 0 && q_err.size() != 0) || (exp_err > 0 && (q_err.size() != 1 || int'(q_err[0]) != exp_err))
            || q_data.size() != 0 || ok_cnt != okc) begin
          n_fail++;
          $display("FAIL rand_err[%0d]: errs=%0d first_code=%0d xfers=%0d ok=%0d, required code %0d, no data, no ok",
                   f, q_err.size(), (q_err.size() > 0) ? int'(q_err[0]) : 0, q_data.size(), ok_cnt - okc, exp_err);
        end
      end
    end
    rdy_rand = 1'b0;
    pkt_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_checksum();
    test_len_noise();
    test_timeout_parity();
    test_overrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
